gray_codec_pipe: RTL and testbench

Pipelined, parametrised Gray-code converter that decodes Gray to binary or encodes binary to Gray on a per-word basis, selected by a mode bit carried with each word. It is the next-generation replacement for the single-register Gray decoder. It adds configurable pipeline depth for high-WIDTH timing closure, an encode mode, and full valid/ready backpressure so it can sit directly between FIFO-style stream stages. Typical placement is on clock-domain-crossing pointer paths and on position-encoder interfaces.

---
 rtl/gray_codec_pipe.sv | 94 +++++++++
 tb/tb_gray_codec_pipe.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter with a per-word mode bit and valid/ready handshaking.
// Decode XOR steps are spread across STAGES registers; encode happens entirely in stage 0.
module gray_codec_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inStrobe,
   output logic             inReady,
   input  logic             inMode,
   input  logic [WIDTH-1:0] dataIn,
   output logic             outStrobe,
   input  logic             outReady,
   output logic             outMode,
   output logic [WIDTH-1:0] dataOut
);

   localparam int SHIFT_NUM = $clog2(WIDTH);

   // Work done by stage k: the decode steps mapped to it, or the single encode step in stage 0.
   function automatic logic [WIDTH-1:0] stage_fn(input int k, input logic [WIDTH-1:0] x,
                                                 input logic enc);
      logic [WIDTH-1:0] r;
      r = x;
      if (enc) begin
         if (k == 0) r = x ^ (x >> 1);
      end else begin
         for (int j = 0; j < SHIFT_NUM; j++) begin
            if ((j * STAGES) / SHIFT_NUM == k) r = r ^ (r >> (1 << (SHIFT_NUM - 1 - j)));
         end
      end
      return r;
   endfunction

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            mode_q, mode_d;
   logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
   logic [STAGES-1:0]            ld;

   // Stage k can take a word if downstream drains or any stage from k to the end has a hole.
   always_comb begin
      ld = '0;
      for (int k = 0; k < STAGES; k++) begin
         ld[k] = outReady;
         for (int m = k; m < STAGES; m++) begin
            if (!valid_q[m]) ld[k] = 1'b1;
         end
      end
   end

   always_comb begin
      logic             src_vld;
      logic             src_mode;
      logic [WIDTH-1:0] src_dat;
      valid_d  = valid_q;
      mode_d   = mode_q;
      data_d   = data_q;
      src_vld  = 1'b0;
      src_mode = 1'b0;
      src_dat  = '0;
      for (int k = 0; k < STAGES; k++) begin
         src_vld  = (k == 0) ? inStrobe : valid_q[(k == 0) ? 0 : k - 1];
         src_mode = (k == 0) ? inMode   : mode_q[(k == 0) ? 0 : k - 1];
         src_dat  = (k == 0) ? dataIn   : data_q[(k == 0) ? 0 : k - 1];
         if (ld[k]) begin
            valid_d[k] = src_vld;
            // Bubbles never overwrite data, so an idle output keeps its last word.
            if (src_vld) begin
               mode_d[k] = src_mode;
               data_d[k] = stage_fn(k, src_dat, src_mode);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         mode_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
      end
   end

   assign inReady   = ld[0];
   assign outStrobe = valid_q[STAGES-1];
   assign outMode   = mode_q[STAGES-1];
   assign dataOut   = data_q[STAGES-1];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: one W8/S3 instance for directed cases, W32 instances with STAGES 1/3/5 for random traffic.
module tb_gray_codec_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_strobe [4];
   logic        in_mode   [4];
   logic        out_ready [4];
   logic [31:0] din       [4];
   logic        in_ready  [4];
   logic        out_strobe[4];
   logic        out_mode  [4];
   logic [31:0] dout      [4];
   logic [7:0]  dout8;

   assign dout[0] = {24'h0, dout8};

   gray_codec_pipe #(.WIDTH(8), .STAGES(3)) u_w8s3 (
      .clk(clk), .rst(rst), .inStrobe(in_strobe[0]), .inReady(in_ready[0]), .inMode(in_mode[0]),
      .dataIn(din[0][7:0]), .outStrobe(out_strobe[0]), .outReady(out_ready[0]),
      .outMode(out_mode[0]), .dataOut(dout8));
   gray_codec_pipe #(.WIDTH(32), .STAGES(1)) u_w32s1 (
      .clk(clk), .rst(rst), .inStrobe(in_strobe[1]), .inReady(in_ready[1]), .inMode(in_mode[1]),
      .dataIn(din[1]), .outStrobe(out_strobe[1]), .outReady(out_ready[1]),
      .outMode(out_mode[1]), .dataOut(dout[1]));
   gray_codec_pipe #(.WIDTH(32), .STAGES(3)) u_w32s3 (
      .clk(clk), .rst(rst), .inStrobe(in_strobe[2]), .inReady(in_ready[2]), .inMode(in_mode[2]),
      .dataIn(din[2]), .outStrobe(out_strobe[2]), .outReady(out_ready[2]),
      .outMode(out_mode[2]), .dataOut(dout[2]));
   gray_codec_pipe #(.WIDTH(32), .STAGES(5)) u_w32s5 (
      .clk(clk), .rst(rst), .inStrobe(in_strobe[3]), .inReady(in_ready[3]), .inMode(in_mode[3]),
      .dataIn(din[3]), .outStrobe(out_strobe[3]), .outReady(out_ready[3]),
      .outMode(out_mode[3]), .dataOut(dout[3]));

   int st_of[4] = '{3, 1, 3, 5};
   int wd_of[4] = '{8, 32, 32, 32};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] q_exp [$];
   logic        q_mode[$];
   logic [31:0] q_orig[$];
   int          q_cyc [$];
   logic [31:0] got   [$];
   logic        got_m [$];

   bit          chk_lat, head_seen, prev_vld, prev_cons;
   logic [31:0] prev_dat;
   logic        prev_mode;
   int          n_acc, n_out;

   function automatic logic [31:0] wmask(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
   endfunction

   // Binary bit i is the parity of all Gray bits at or above i.
   function automatic logic [31:0] ref_dec(input logic [31:0] g, input int w);
      logic [31:0] r;
      logic        a;
      r = '0;
      a = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (i < w) begin
            a    = a ^ g[i];
            r[i] = a;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_enc(input logic [31:0] b, input int w);
      logic [32:0] bb;
      logic [31:0] r;
      bb = {1'b0, b & wmask(w)};
      r  = '0;
      for (int i = 0; i < 32; i++) if (i < w) r[i] = bb[i] ^ bb[i+1];
      return r;
   endfunction

   task automatic drive(input int d, input logic s, input logic m, input logic [31:0] x,
                        input logic r);
      in_strobe[d] = s;
      in_mode[d]   = m;
      din[d]       = x & wmask(wd_of[d]);
      out_ready[d] = r;
   endtask

   task automatic start(input int d, input bit lat);
      q_exp.delete(); q_mode.delete(); q_orig.delete(); q_cyc.delete();
      got.delete(); got_m.delete();
      head_seen = 0;
      prev_vld  = 0;
      prev_cons = 0;
      prev_dat  = dout[d];
      prev_mode = out_mode[d];
      n_acc     = 0;
      n_out     = 0;
      chk_lat   = lat;
   endtask

   // One clock cycle: sample just after inputs settle, score handshakes, advance to next negedge.
   task automatic tick(input int d, output bit acc, output bit ovld);
      bit cons;
      #1;
      acc  = in_strobe[d] && in_ready[d];
      cons = out_strobe[d] && out_ready[d];
      ovld = out_strobe[d];
      if (prev_vld && !prev_cons) begin
         checks++;
         if (out_strobe[d] !== 1'b1 || dout[d] !== prev_dat || out_mode[d] !== prev_mode) begin
            errors++;
            $display("FAIL hold_stable dut%0d cyc%0d: vld=%b dat=%h mode=%b, required vld=1 dat=%h mode=%b",
                     d, cyc, out_strobe[d], dout[d], out_mode[d], prev_dat, prev_mode);
         end
      end else if (!out_strobe[d]) begin
         checks++;
         if (dout[d] !== prev_dat || out_mode[d] !== prev_mode) begin
            errors++;
            $display("FAIL idle_stable dut%0d cyc%0d: dat=%h mode=%b, required dat=%h mode=%b",
                     d, cyc, dout[d], out_mode[d], prev_dat, prev_mode);
         end
      end
      if (out_strobe[d] && !head_seen) begin
         head_seen = 1;
         if (chk_lat && q_cyc.size() > 0) begin
            checks++;
            if (cyc !== q_cyc[0] + st_of[d]) begin
               errors++;
               $display("FAIL latency dut%0d: word seen at cyc %0d, required %0d",
                        d, cyc, q_cyc[0] + st_of[d]);
            end
         end
      end
      if (cons) begin
         head_seen = 0;
         checks++;
         if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL spurious_out dut%0d cyc%0d: got %h with no word outstanding", d, cyc, dout[d]);
         end else begin
            checks++;
            if (dout[d] !== q_exp[0] || out_mode[d] !== q_mode[0]) begin
               errors++;
               $display("FAIL data dut%0d cyc%0d: got %h mode %b, required %h mode %b",
                        d, cyc, dout[d], out_mode[d], q_exp[0], q_mode[0]);
            end
            if (q_mode[0]) begin
               checks++;
               if (ref_dec(dout[d], wd_of[d]) !== q_orig[0]) begin
                  errors++;
                  $display("FAIL roundtrip dut%0d: decode(%h)=%h, required %h",
                           d, dout[d], ref_dec(dout[d], wd_of[d]), q_orig[0]);
               end
            end
            void'(q_exp.pop_front()); void'(q_mode.pop_front());
            void'(q_orig.pop_front()); void'(q_cyc.pop_front());
         end
         got.push_back(dout[d]);
         got_m.push_back(out_mode[d]);
         n_out++;
      end
      if (acc) begin
         q_exp.push_back(in_mode[d] ? ref_enc(din[d], wd_of[d]) : ref_dec(din[d], wd_of[d]));
         q_mode.push_back(in_mode[d]);
         q_orig.push_back(din[d]);
         q_cyc.push_back(cyc);
         n_acc++;
      end
      prev_vld  = out_strobe[d];
      prev_cons = cons;
      prev_dat  = dout[d];
      prev_mode = out_mode[d];
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input int d);
      bit a, v;
      drive(d, 0, 0, 0, 1);
      for (int i = 0; i < 60 && q_exp.size() > 0; i++) tick(d, a, v);
      checks++;
      if (q_exp.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout dut%0d: %0d words outstanding, required 0", d, q_exp.size());
      end
   endtask

   task automatic test_reset();
      bit a, v;
      for (int d = 0; d < 4; d++) drive(d, 0, 0, 0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (out_strobe[d] !== 1'b0 || dout[d] !== 32'h0 || out_mode[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dut%0d: vld=%b dat=%h mode=%b, required 0/0/0",
                     d, out_strobe[d], dout[d], out_mode[d]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (in_ready[d] !== 1'b1 || out_strobe[d] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset dut%0d: inReady=%b outStrobe=%b, required 1/0",
                     d, in_ready[d], out_strobe[d]);
         end
      end
      start(0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 1, 32'hF0, 0);
         tick(0, a, v);
      end
      checks++;
      if (out_strobe[0] !== 1'b1 || in_ready[0] !== 1'b0 || dout[0] !== 32'h88) begin
         errors++;
         $display("FAIL full_before_reset: vld=%b rdy=%b dat=%h, required 1/0/88",
                  out_strobe[0], in_ready[0], dout[0]);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_strobe[0] !== 1'b0 || dout[0] !== 32'h0 || out_mode[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: vld=%b dat=%h mode=%b, required 0/0/0",
                  out_strobe[0], dout[0], out_mode[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready[0] !== 1'b1 || out_strobe[0] !== 1'b0) begin
         errors++;
         $display("FAIL release_reset: inReady=%b outStrobe=%b, required 1/0", in_ready[0], out_strobe[0]);
      end
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
   endtask

   task automatic test_decode();
      logic [31:0] vin [4] = '{32'h0C, 32'h80, 32'hFF, 32'h01};
      logic [31:0] vout[4] = '{32'h08, 32'hFF, 32'hAA, 32'h01};
      bit a, v;
      start(0, 1);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, vin[i], 1);
         tick(0, a, v);
      end
      drain(0);
      checks++;
      if (got.size() != 4) begin
         errors++;
         $display("FAIL decode_count: got %0d words, required 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== vout[i] || got_m[i] !== 1'b0) begin
               errors++;
               $display("FAIL decode_value[%0d]: got %h mode %b, required %h mode 0",
                        i, got[i], got_m[i], vout[i]);
            end
         end
      end
   endtask

   task automatic test_mixed();
      bit a, v;
      start(0, 1);
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, (i % 2 == 0), (i % 2 == 0) ? 32'h08 : 32'h0C, 1);
         tick(0, a, v);
      end
      drain(0);
      checks++;
      if (got.size() != 6) begin
         errors++;
         $display("FAIL mixed_count: got %0d words, required 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== ((i % 2 == 0) ? 32'h0C : 32'h08) || got_m[i] !== (i % 2 == 0)) begin
               errors++;
               $display("FAIL mixed_value[%0d]: got %h mode %b", i, got[i], got_m[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w[5];
      int idx = 0;
      bit a, v;
      for (int i = 0; i < 5; i++) w[i] = $urandom_range(1, 255);
      start(0, 0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, i[0], w[idx], 0);
         tick(0, a, v);
         if (a) idx++;
      end
      #1;
      checks++;
      if (idx != 3 || in_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill: accepted %0d inReady=%b, required 3 and 0", idx, in_ready[0]);
      end
      for (int i = 0; i < 30 && idx < 5; i++) begin
         drive(0, 1, idx[0], w[idx], 1);
         tick(0, a, v);
         if (a) idx++;
      end
      drain(0);
      checks++;
      if (n_out != 5 || got.size() != 5) begin
         errors++;
         $display("FAIL bp_count: got %0d words, required 5", n_out);
      end
   endtask

   task automatic test_bubbles(input int d);
      int highs = 0;
      bit a, v, pv;
      pv = 0;
      start(d, 1);
      for (int i = 0; i < 24 + st_of[d]; i++) begin
         drive(d, (i % 3 == 0) && (i < 24), $urandom_range(0, 1), $urandom, 1);
         tick(d, a, v);
         if (v) highs++;
         checks++;
         if (v && pv) begin
            errors++;
            $display("FAIL bubble_gap dut%0d cyc%0d: outStrobe high two cycles running", d, cyc);
         end
         pv = v;
      end
      drain(d);
      checks++;
      if (highs != 8 || n_out != 8) begin
         errors++;
         $display("FAIL bubble_count dut%0d: %0d strobes %0d words, required 8 and 8", d, highs, n_out);
      end
   endtask

   task automatic test_random(input int d);
      bit a, v;
      start(d, 0);
      for (int i = 0; i < 400; i++) begin
         drive(d, $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0);
         tick(d, a, v);
      end
      drain(d);
      checks++;
      if (n_out != n_acc) begin
         errors++;
         $display("FAIL random_count dut%0d: %0d out, required %0d", d, n_out, n_acc);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mixed();
      test_backpressure();
      test_bubbles(0);
      test_bubbles(3);
      for (int d = 1; d < 4; d++) test_random(d);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
